aes_stream_cipher: RTL and testbench
====================================

Name: aes_stream_cipher

Overview:
- Byte-wide counter-mode stream cipher built on the AES S-box.
- Each valid input byte is XORed with a keystream byte derived from an 8-bit counter and an 8-bit key.
- Result is registered together with the counter value that produced it.
- Encrypt and decrypt are the same operation; the block sits between a byte source and sink in the HES datapath.

Parameters:
- CTR_INIT, 8'h00, counter value used for the first byte of every message and the value loaded at reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-high
- key  input  8  cipher key, sampled on every accepted beat; must be held stable during a message
- input_valid  input  1  input_data is valid this cycle; beat accepted on rising clk edge
- new_message  input  1  qualified by input_valid; accepted beat is first byte of a new message
- input_data  input  8  plaintext or ciphertext byte
- output_valid  output  1  output_byte/counter_block valid; single-cycle per accepted beat
- output_byte  output  8  input_data XOR keystream
- counter_block  output  8  counter value used to produce output_byte

Behaviour:
- Reset (rst_n asserted, asynchronous): output_valid=0, output_byte=8'h00, counter_block=8'h00, internal counter ctr=CTR_INIT. Reset mid-message discards all state; the next message must start with new_message.
- Counter select per accepted beat: c = CTR_INIT if new_message=1, else c = ctr.
- Keystream: ks = SBOX(c XOR key). SBOX is the standard AES forward S-box, full 256-entry combinational table.
- On a rising edge with input_valid=1:
  - output_byte <= input_data XOR ks
  - counter_block <= c
  - output_valid <= 1
  - ctr <= c + 1, modulo 256; 8'hFF wraps to 8'h00 with no flag or stall.
- On a rising edge with input_valid=0: output_valid <= 0; output_byte, counter_block and ctr hold. new_message is ignored when input_valid=0.
- Latency: exactly 1 cycle from accepted beat to output_valid. Throughput: 1 byte/cycle, back-to-back beats allowed, no backpressure.
- new_message on consecutive beats: each such beat restarts at CTR_INIT.
- The first message after reset without new_message uses ctr=CTR_INIT (same result as with new_message).
- key is not registered; it is used combinationally at each accepted beat.

Optional Feature:
- Macro CIPHER_DOUBLE_ROUND_EN.
- Defined: ks = SBOX(SBOX(c XOR key) XOR key), i.e. a second substitution round. Latency, handshake and counter behaviour are unchanged; the two S-box lookups are chained combinationally within the cycle.
- Undefined: single round, ks = SBOX(c XOR key).

Test Plan:
- Reset then key=8'h00, three back-to-back beats of input_data=8'h00, new_message=1 on the first only -> output_byte 63,7C,77; counter_block 00,01,02; output_valid high exactly 1 cycle after each beat.
- key=8'hFF, new_message=1, input_data=8'h00 -> output_byte=8'h16, counter_block=8'h00. Feed output back (input_data=8'h16, new_message=1, same key) -> output_byte=8'h00 (round-trip decryption).
- Bubble: beat (new_message=1), one idle cycle, beat; key=0, data=0 -> output_valid low during the gap; second result 7C with counter_block=01 (counter held across the gap).
- Wrap: key=0, data=0, 257 consecutive beats after new_message -> beat 256 gives counter_block=FF, output 16; beat 257 gives counter_block=00, output 63.
- Mid-message new_message: after 5 beats assert new_message again -> counter_block returns to 00, output 63. Assert rst_n mid-stream -> outputs clear to 0 immediately, asynchronously.
- With CIPHER_DOUBLE_ROUND_EN: key=0, data=0, new_message=1 -> output_byte=8'hFB, counter_block=00.

Source files
------------

// File: rtl/aes_stream_cipher.sv
// aes_stream_cipher
//
// Byte-wide counter-mode stream cipher built on the AES forward S-box.
// Each accepted byte is XORed with a keystream byte derived from an 8-bit
// counter and an 8-bit key. The result is registered together with the
// counter value that produced it. Encryption and decryption are the same
// operation.
//
// Optional feature macro: CIPHER_DOUBLE_ROUND_EN
//   undefined : ks = SBOX(c ^ key)
//   defined   : ks = SBOX(SBOX(c ^ key) ^ key), both lookups in one cycle
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous reset, active-high (historical name)
//   key           8-bit key, used combinationally on each accepted beat
//   input_valid   input_data valid, beat accepted on rising clk edge
//   new_message   with input_valid: beat is first byte of a new message
//   input_data    plaintext or ciphertext byte
//   output_valid  one-cycle pulse per accepted beat
//   output_byte   input_data XOR keystream
//   counter_block counter value used for output_byte

module aes_stream_cipher #(
    parameter logic [7:0] CTR_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key,
    input  logic       input_valid,
    input  logic       new_message,
    input  logic [7:0] input_data,
    output logic       output_valid,
    output logic [7:0] output_byte,
    output logic [7:0] counter_block
);

    // S-box packed with entry 0x00 in the most significant byte, so entry
    // x lives at bit offset 8*(255-x), i.e. {~x, 3'b000}.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] offset;
        offset = {~x, 3'b000};
        return SBOX_TABLE[offset +: 8];
    endfunction

    logic [7:0] ctr;
    logic [7:0] ctr_sel;
    logic [7:0] ks;

    // A new message always restarts at CTR_INIT; otherwise continue from
    // the running counter.
    always_comb begin
        ctr_sel = new_message ? CTR_INIT : ctr;
`ifdef CIPHER_DOUBLE_ROUND_EN
        ks = sbox(sbox(ctr_sel ^ key) ^ key);
`else
        ks = sbox(ctr_sel ^ key);
`endif
    end

    // Output registers and running counter. Idle cycles only drop the
    // valid pulse; data, counter_block and counter all hold.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            output_valid  <= 1'b0;
            output_byte   <= 8'h00;
            counter_block <= 8'h00;
            ctr           <= CTR_INIT;
        end else if (input_valid) begin
            output_valid  <= 1'b1;
            output_byte   <= input_data ^ ks;
            counter_block <= ctr_sel;
            ctr           <= ctr_sel + 8'd1;
        end else begin
            output_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_stream_cipher.sv
// tb_aes_stream_cipher
//
// Directed testbench for aes_stream_cipher. Expected values are hand-derived
// from the AES S-box; separate constants cover the double-round build.

module tb_aes_stream_cipher;

    logic       clk;
    logic       rst_n;
    logic [7:0] key;
    logic       input_valid;
    logic       new_message;
    logic [7:0] input_data;
    logic       output_valid;
    logic [7:0] output_byte;
    logic [7:0] counter_block;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef CIPHER_DOUBLE_ROUND_EN
    localparam logic [7:0] EXP_K0_C00 = 8'hfb;
    localparam logic [7:0] EXP_K0_C01 = 8'h10;
    localparam logic [7:0] EXP_K0_C02 = 8'hf5;
    localparam logic [7:0] EXP_K0_CFF = 8'h47;
    localparam logic [7:0] EXP_KFF_C00 = 8'h1e;
`else
    localparam logic [7:0] EXP_K0_C00 = 8'h63;
    localparam logic [7:0] EXP_K0_C01 = 8'h7c;
    localparam logic [7:0] EXP_K0_C02 = 8'h77;
    localparam logic [7:0] EXP_K0_CFF = 8'h16;
    localparam logic [7:0] EXP_KFF_C00 = 8'h16;
`endif

    aes_stream_cipher #(.CTR_INIT(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key           (key),
        .input_valid   (input_valid),
        .new_message   (new_message),
        .input_data    (input_data),
        .output_valid  (output_valid),
        .output_byte   (output_byte),
        .counter_block (counter_block)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if it mismatches.
    task automatic checkOutput(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %02h, expected %02h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, then waits past the capturing edge so the
    // registered result of that cycle is visible.
    task automatic applyStimulus(input logic valid, input logic nm,
                                 input logic [7:0] data);
        input_valid = valid;
        new_message = nm;
        input_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b1;
        input_valid = 1'b0;
        new_message = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        key         = 8'h00;
        input_valid = 1'b0;
        new_message = 1'b0;
        input_data  = 8'h00;
        #12;
        checkOutput("reset_valid", {7'b0, output_valid}, 8'h00);
        checkOutput("reset_byte", output_byte, 8'h00);
        checkOutput("reset_ctr", counter_block, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Three back-to-back beats, new_message on the first only
        key = 8'h00;
        applyStimulus(1'b1, 1'b1, 8'h00);
        checkOutput("b2b0_valid", {7'b0, output_valid}, 8'h01);
        checkOutput("b2b0_byte", output_byte, EXP_K0_C00);
        checkOutput("b2b0_ctr", counter_block, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("b2b1_valid", {7'b0, output_valid}, 8'h01);
        checkOutput("b2b1_byte", output_byte, EXP_K0_C01);
        checkOutput("b2b1_ctr", counter_block, 8'h01);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("b2b2_byte", output_byte, EXP_K0_C02);
        checkOutput("b2b2_ctr", counter_block, 8'h02);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("b2b_end_valid", {7'b0, output_valid}, 8'h00);

        // key FF, encrypt then decrypt round trip
        key = 8'hff;
        applyStimulus(1'b1, 1'b1, 8'h00);
        checkOutput("kff_enc_byte", output_byte, EXP_KFF_C00);
        checkOutput("kff_enc_ctr", counter_block, 8'h00);
        applyStimulus(1'b1, 1'b1, EXP_KFF_C00);
        checkOutput("kff_dec_byte", output_byte, 8'h00);
        checkOutput("kff_dec_ctr", counter_block, 8'h00);

        // Bubble: counter and outputs hold across an idle cycle; a
        // new_message strobe without input_valid is ignored
        key = 8'h00;
        applyStimulus(1'b1, 1'b1, 8'h00);
        checkOutput("bub0_byte", output_byte, EXP_K0_C00);
        applyStimulus(1'b0, 1'b1, 8'h55);
        checkOutput("bub_gap_valid", {7'b0, output_valid}, 8'h00);
        checkOutput("bub_gap_byte", output_byte, EXP_K0_C00);
        checkOutput("bub_gap_ctr", counter_block, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("bub1_valid", {7'b0, output_valid}, 8'h01);
        checkOutput("bub1_byte", output_byte, EXP_K0_C01);
        checkOutput("bub1_ctr", counter_block, 8'h01);

        // Nonzero data XOR: A5 ^ ks(ctr 2)
        applyStimulus(1'b1, 1'b0, 8'ha5);
        checkOutput("xor_byte", output_byte, 8'ha5 ^ EXP_K0_C02);
        checkOutput("xor_ctr", counter_block, 8'h02);

        // Wrap: 257 beats, counter_block tracks beat index modulo 256
        for (int i = 1; i <= 257; i++) begin
            applyStimulus(1'b1, (i == 1), 8'h00);
            checkOutput($sformatf("wrap_ctr_%0d", i), counter_block, 8'((i - 1) % 256));
            if (i == 1)   checkOutput("wrap_first_byte", output_byte, EXP_K0_C00);
            if (i == 256) checkOutput("wrap_ff_byte", output_byte, EXP_K0_CFF);
            if (i == 257) checkOutput("wrap_00_byte", output_byte, EXP_K0_C00);
        end

        // Mid-message restart after 5 beats
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, (i == 0), 8'h00);
        checkOutput("mid_pre_ctr", counter_block, 8'h04);
        applyStimulus(1'b1, 1'b1, 8'h00);
        checkOutput("mid_restart_ctr", counter_block, 8'h00);
        checkOutput("mid_restart_byte", output_byte, EXP_K0_C00);

        // Consecutive new_message beats each restart
        applyStimulus(1'b1, 1'b1, 8'h00);
        checkOutput("nm_again_ctr", counter_block, 8'h00);

        // Asynchronous reset mid-stream, away from any clock edge
        applyStimulus(1'b1, 1'b0, 8'h00);
        input_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("async_rst_valid", {7'b0, output_valid}, 8'h00);
        checkOutput("async_rst_byte", output_byte, 8'h00);
        checkOutput("async_rst_ctr", counter_block, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;

        // First message after reset without new_message starts at CTR_INIT
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("post_rst_byte", output_byte, EXP_K0_C00);
        checkOutput("post_rst_ctr", counter_block, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("post_rst2_ctr", counter_block, 8'h01);

        // Reset via helper, then confirm clean state again
        doReset();
        checkOutput("final_rst_ctr", counter_block, 8'h00);
        checkOutput("final_rst_valid", {7'b0, output_valid}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
